// File: rtl/pipelined_mac_pkg.sv
// pipelined_mac_pkg
// Shared definitions for the pipelined multiply-add/accumulate unit:
// mode encodings and default operand/accumulator widths.
package pipelined_mac_pkg;

   localparam int MAC_WIDTH_DEF     = 8;
   localparam int MAC_ACC_WIDTH_DEF = 16;

   typedef enum logic {
      MAC_MODE_MULADD = 1'b0,
      MAC_MODE_ACC    = 1'b1
   } mac_mode_e;

endpackage

// File: rtl/pipelined_mac_sat_add.sv
// sat_add
// Combinational adder used in the accumulate stage. Adds two ACC_WIDTH
// values at ACC_WIDTH+1 bits, reports the carry-out as overflow and, when
// SAT is set, clamps an overflowing result to all-ones.
// Ports:
//   p       in   ACC_WIDTH  zero-extended product
//   addend  in   ACC_WIDTH  c or accumulator
//   result  out  ACC_WIDTH  wrapped or clamped sum
//   ovf     out  1          sum did not fit in ACC_WIDTH bits
module sat_add #(
   parameter int ACC_WIDTH = 16,
   parameter int SAT       = 0
) (
   input  logic [ACC_WIDTH-1:0] p,
   input  logic [ACC_WIDTH-1:0] addend,
   output logic [ACC_WIDTH-1:0] result,
   output logic                 ovf
);

   logic [ACC_WIDTH:0] sum;

   assign sum    = {1'b0, p} + {1'b0, addend};
   assign ovf    = sum[ACC_WIDTH];
   assign result = ((SAT != 0) && ovf) ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];

endmodule

// File: rtl/pipelined_mac.sv
// pipelined_mac
// Pipelined unsigned multiply-add (mode 0: a*b+c) / accumulate
// (mode 1: acc+a*b, or c+a*b when acc_clr) with optional saturation.
// Beats are registered at the input boundary, multiplied (S1), added and
// accumulated (S2) and presented on the output register (S3), so a beat
// accepted at edge k is visible after edge k+3. The whole pipe advances
// together whenever the output register is empty or being consumed.
// Ports:
//   clk, rst_n           clock (rising edge), async active-low reset
//   in_valid/in_ready    input handshake; in_ready is combinational
//   a, b                 WIDTH-bit unsigned operands
//   c                    ACC_WIDTH addend / accumulator seed
//   mode, acc_clr        operation select, accumulator seed select
//   out_valid/out_ready  output handshake
//   data_out, ovf        result and overflow flag
module pipelined_mac
   import pipelined_mac_pkg::*;
#(
   parameter int WIDTH     = MAC_WIDTH_DEF,
   parameter int ACC_WIDTH = MAC_ACC_WIDTH_DEF,
   parameter int SAT       = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic [ACC_WIDTH-1:0] c,
   input  logic                 mode,
   input  logic                 acc_clr,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ACC_WIDTH-1:0] data_out,
   output logic                 ovf
);

   generate
      if (ACC_WIDTH < 2*WIDTH) begin : g_width_check
         $error("pipelined_mac: ACC_WIDTH must be >= 2*WIDTH");
      end
   endgenerate

   logic advance;

   // operand register
   logic                 op_valid;
   logic [WIDTH-1:0]     op_a;
   logic [WIDTH-1:0]     op_b;
   logic [ACC_WIDTH-1:0] op_c;
   mac_mode_e            op_mode;
   logic                 op_clr;

   // S1: product
   logic                 s1_valid;
   logic [ACC_WIDTH-1:0] s1_p;
   logic [ACC_WIDTH-1:0] s1_c;
   mac_mode_e            s1_mode;
   logic                 s1_clr;

   // S2: sum and accumulator
   logic                 s2_valid;
   logic [ACC_WIDTH-1:0] s2_res;
   logic                 s2_ovf;
   logic [ACC_WIDTH-1:0] acc;

   logic [2*WIDTH-1:0]   prod;
   logic [ACC_WIDTH-1:0] addend;
   logic [ACC_WIDTH-1:0] add_res;
   logic                 add_ovf;

   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   assign prod = {{WIDTH{1'b0}}, op_a} * {{WIDTH{1'b0}}, op_b};

   // acc_clr only matters in accumulate mode; mode 0 always adds c
   assign addend = ((s1_mode == MAC_MODE_MULADD) || s1_clr) ? s1_c : acc;

   sat_add #(
      .ACC_WIDTH (ACC_WIDTH),
      .SAT       (SAT)
   ) u_sat_add (
      .p      (s1_p),
      .addend (addend),
      .result (add_res),
      .ovf    (add_ovf)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_valid  <= 1'b0;
         op_a      <= '0;
         op_b      <= '0;
         op_c      <= '0;
         op_mode   <= MAC_MODE_MULADD;
         op_clr    <= 1'b0;
         s1_valid  <= 1'b0;
         s1_p      <= '0;
         s1_c      <= '0;
         s1_mode   <= MAC_MODE_MULADD;
         s1_clr    <= 1'b0;
         s2_valid  <= 1'b0;
         s2_res    <= '0;
         s2_ovf    <= 1'b0;
         acc       <= '0;
         out_valid <= 1'b0;
         data_out  <= '0;
         ovf       <= 1'b0;
      end else if (advance) begin
         op_valid <= in_valid;
         if (in_valid) begin
            op_a    <= a;
            op_b    <= b;
            op_c    <= c;
            op_mode <= mac_mode_e'(mode);
            op_clr  <= acc_clr;
         end

         s1_valid <= op_valid;
         if (op_valid) begin
            s1_p    <= ACC_WIDTH'(prod);
            s1_c    <= op_c;
            s1_mode <= op_mode;
            s1_clr  <= op_clr;
         end

         // acc is read and written here only, so consecutive mode-1
         // beats chain without forwarding
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_res <= add_res;
            s2_ovf <= add_ovf;
            if (s1_mode == MAC_MODE_ACC) begin
               acc <= add_res;
            end
         end

         out_valid <= s2_valid;
         if (s2_valid) begin
            data_out <= s2_res;
            ovf      <= s2_ovf;
         end
      end
   end

endmodule

// File: doc/pipelined_mac.md
Name: pipelined_mac

Overview:
Parametrised 3-stage pipelined multiply-add/accumulate unit. It replaces fixed 8-bit multiply-then-add pipelines in datapath blocks. Each beat computes a*b+c (mode 0) or acc+a*b (mode 1) at full product width, with optional saturation and an overflow flag. Valid/ready handshake on both sides; one beat per cycle when not stalled.

Parameters:
WIDTH, 8, width of unsigned operands a and b
ACC_WIDTH, 16, width of c, accumulator and data_out; must be >= 2*WIDTH (elaboration error otherwise)
SAT, 0, 1 = clamp result to 2^ACC_WIDTH-1 on overflow; 0 = wrap modulo 2^ACC_WIDTH

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  unit can accept a beat this cycle
a  in  WIDTH  multiplicand, unsigned
b  in  WIDTH  multiplier, unsigned
c  in  ACC_WIDTH  addend (mode 0) or accumulator seed (mode 1 with acc_clr)
mode  in  1  0 = multiply-add, 1 = accumulate
acc_clr  in  1  mode 1 only: seed accumulator from c instead of acc
out_valid  out  1  data_out/ovf valid
out_ready  in  1  downstream accepts result
data_out  out  ACC_WIDTH  result
ovf  out  1  result overflowed ACC_WIDTH bits (flagged for SAT=0 and SAT=1)

Behaviour:
- Reset (async, rst_n=0): all stage valids 0, acc 0, data_out 0, ovf 0, out_valid 0 immediately; in-flight beats discarded. After release in_ready=1.
- advance = !out_valid || out_ready; in_ready = advance (combinational). Beat accepted on edge where in_valid && in_ready.
- When advance=0 all three stages and acc hold; data_out/ovf stable; no loss or duplication. Stall is global; bubbles are not compressed.
- S1: p = a*b (2*WIDTH, zero-extended to ACC_WIDTH); capture c, mode, acc_clr, valid.
- S2: addend = mode0 ? c : (acc_clr ? c : acc). sum = p + addend computed ACC_WIDTH+1 bits; ovf = sum[ACC_WIDTH]. Result = SAT && ovf ? all-ones : sum[ACC_WIDTH-1:0].
- acc updates to result only when S2 captures a valid mode-1 beat; mode-0 beats never modify acc. Back-to-back mode-1 beats chain correctly with no hazard, because acc is read and written in S2.
- S3: data_out/ovf load only on valid beats. They hold their last delivered value when out_valid=0.
- Latency: beat accepted at edge k appears with out_valid=1 after edge k+3 when unstalled. Throughput 1 beat/cycle. Results stay in acceptance order.
- in_valid=0 inserts a bubble. Bubbles propagate as out_valid=0 and do not touch acc.
- acc_clr with mode=0 is ignored.
- Overflow: accumulator wrap (SAT=0) keeps the low ACC_WIDTH bits in acc. SAT=1 keeps the clamped value in acc.

Decomposition:
- Shared package pipelined_mac_pkg: mode encodings MAC_MODE_MULADD=0, MAC_MODE_ACC=1; default WIDTH/ACC_WIDTH constants.
- One sub-module: sat_add (combinational; ACC_WIDTH+1 sum, ovf, SAT clamp). Used in S2.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> out_valid=0, data_out=0, ovf=0; after release in_ready=1.
- Mode 0, back-to-back, out_ready=1, SAT=0:
  - (3,4,5) -> 17, ovf=0
  - (255,255,0) -> 65025
  - (255,255,65535) -> 65024, ovf=1
  - Results on 3 consecutive cycles, 3 cycles after acceptance.
- SAT=1, same three beats -> 17, 65025, 65535 with ovf=0,0,1.
- Accumulate:
  - mode1 clr (2,3,c=10) -> 16
  - mode1 (4,5) -> 36
  - mode0 (1,1,0) -> 1
  - mode1 (1,1) -> 37; the interleaved mode-0 beat leaves acc untouched.
- Backpressure: 3 beats in flight, out_ready=0 for 4 cycles -> in_ready=0 throughout, data_out stable; after release the 3 results appear in order, none duplicated or lost.
- Reset mid-stream: pulse rst_n low with 2 mode-1 beats in flight -> out_valid drops immediately, acc=0; after release mode1 no-clr (1,1) -> 1.
